// File: rtl/apb_nslv_bridge_if.sv
// APB link bundle shared by the upstream port (N_SEL = 1) and the fanned-out downstream port.
// Select, enable and response signals carry one bit per slave on the downstream side.
interface apb_nslv_bridge_if #(
    parameter int unsigned N_SEL  = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [N_SEL-1:0]        psel;
    logic [N_SEL-1:0]        penable;
    logic [ADDR_W-1:0]       paddr;
    logic                    pwrite;
    logic [DATA_W/8-1:0]     pstrb;
    logic [2:0]              pprot;
    logic [DATA_W-1:0]       pwdata;
    logic [N_SEL*DATA_W-1:0] prdata;
    logic [N_SEL-1:0]        pready;
    logic [N_SEL-1:0]        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_nslv_bridge.sv
// APB fan-out from one upstream port to N_SLV slaves, with an error slave for unmapped
// indices, a per-transfer PREADY timeout and a sticky first-error capture register.
module apb_nslv_bridge #(
    parameter int unsigned N_SLV   = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned SEL_W   = 1,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rstn,
    apb_nslv_bridge_if.slave  s_apb,
    apb_nslv_bridge_if.master m_apb,
    input  logic              err_clr,
    output logic              err_irq,
    output logic [1:0]        err_type,
    output logic [ADDR_W-1:0] err_addr
);
    localparam int unsigned      CntW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0]  CntLast    = CntW'(TIMEOUT - 1);
    localparam logic [1:0]       ErrUnmap   = 2'b01;
    localparam logic [1:0]       ErrTimeout = 2'b10;
    localparam logic [1:0]       ErrSlave   = 2'b11;

    typedef enum logic {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    dec, idx_q, idx_d;
    logic                unmap_q, unmap_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sl_ready, sl_err;
    logic [DATA_W-1:0]   sl_rdata;
    logic [N_SLV-1:0]    psel_c, penable_c;
    logic                pready_c, pslverr_c, timeout_c, done;
    logic [DATA_W-1:0]   prdata_c;
    logic [1:0]          err_kind;
    logic                err_irq_q, err_irq_d;
    logic [1:0]          err_type_q, err_type_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

    assign dec = s_apb.paddr[SEL_LSB +: SEL_W];

    assign m_apb.paddr  = s_apb.paddr;
    assign m_apb.pwrite = s_apb.pwrite;
    assign m_apb.pstrb  = s_apb.pstrb;
    assign m_apb.pprot  = s_apb.pprot;
    assign m_apb.pwdata = s_apb.pwdata;

    always_comb begin
        sl_ready = 1'b0;
        sl_err   = 1'b0;
        sl_rdata = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sl_ready = m_apb.pready[i];
                sl_err   = m_apb.pslverr[i];
                sl_rdata = m_apb.prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        unmap_d   = unmap_q;
        cnt_d     = cnt_q;
        psel_c    = '0;
        penable_c = '0;
        pready_c  = 1'b0;
        pslverr_c = 1'b0;
        prdata_c  = '0;
        timeout_c = 1'b0;
        case (state_q)
            StIdle: begin
                for (int unsigned i = 0; i < N_SLV; i++) begin
                    if (dec == SEL_W'(i)) psel_c[i] = s_apb.psel[0];
                end
                if (s_apb.psel[0] && !s_apb.penable[0]) begin
                    state_d = StAccess;
                    idx_d   = dec;
                    unmap_d = (32'(dec) >= N_SLV);
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                if (unmap_q) begin
                    pready_c  = 1'b1;
                    pslverr_c = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < N_SLV; i++) begin
                        if (idx_q == SEL_W'(i)) begin
                            psel_c[i]    = s_apb.psel[0];
                            penable_c[i] = s_apb.penable[0];
                        end
                    end
                    // A slave that becomes ready in the timeout cycle still wins.
                    if (sl_ready) begin
                        pready_c  = 1'b1;
                        pslverr_c = sl_err;
                        prdata_c  = sl_rdata;
                    end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
                        timeout_c = 1'b1;
                        pready_c  = 1'b1;
                        pslverr_c = 1'b1;
                    end else begin
                        pslverr_c = sl_err;
                        prdata_c  = sl_rdata;
                    end
                    if (s_apb.penable[0] && !sl_ready) cnt_d = cnt_q + 1'b1;
                end
                if (!s_apb.psel[0] || (pready_c && s_apb.penable[0])) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign done     = pready_c & s_apb.penable[0];
    assign err_kind = unmap_q ? ErrUnmap : (timeout_c ? ErrTimeout : ErrSlave);

    always_comb begin
        err_irq_d  = err_irq_q;
        err_type_d = err_type_q;
        err_addr_d = err_addr_q;
        if (done && pslverr_c && (!err_irq_q || err_clr)) begin
            err_irq_d  = 1'b1;
            err_type_d = err_kind;
            err_addr_d = s_apb.paddr;
        end else if (err_clr) begin
            err_irq_d  = 1'b0;
            err_type_d = '0;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            unmap_q    <= 1'b0;
            cnt_q      <= '0;
            err_irq_q  <= 1'b0;
            err_type_q <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            unmap_q    <= unmap_d;
            cnt_q      <= cnt_d;
            err_irq_q  <= err_irq_d;
            err_type_q <= err_type_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Gated by rstn so selects and responses drop at once even while the master holds psel.
    assign m_apb.psel     = {N_SLV{rstn}} & psel_c;
    assign m_apb.penable  = {N_SLV{rstn}} & penable_c;
    assign s_apb.pready   = rstn & pready_c;
    assign s_apb.pslverr  = rstn & pslverr_c;
    assign s_apb.prdata   = rstn ? prdata_c : '0;

    assign err_irq  = err_irq_q;
    assign err_type = err_type_q;
    assign err_addr = err_addr_q;
endmodule

// File: tb/tb_apb_nslv_bridge.sv
// Self-checking bench: transaction-level model of the bridge (cycle number within a transfer,
// target slave behaviour, sticky error register) compared against the DUT on every cycle.
module tb_apb_nslv_bridge;
    localparam int unsigned NS = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          err_clr = 1'b0;
    logic          err_irq;
    logic [1:0]    err_type;
    logic [AW-1:0] err_addr;

    apb_nslv_bridge_if #(.N_SEL(1),  .ADDR_W(AW), .DATA_W(DW)) up ();
    apb_nslv_bridge_if #(.N_SEL(NS), .ADDR_W(AW), .DATA_W(DW)) dn ();

    apb_nslv_bridge #(
        .N_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_LSB(12), .SEL_W(2), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .s_apb(up), .m_apb(dn),
        .err_clr(err_clr), .err_irq(err_irq), .err_type(err_type), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    bit            exp_on  = 1'b0;
    logic [NS-1:0] exp_psel, exp_pen;
    logic          exp_rdy, exp_err;
    logic [DW-1:0] exp_rdata;
    bit            m_irq;
    logic [1:0]    m_type;
    logic [AW-1:0] m_addr;
    bit            clr_force, clr_rand;
    logic [NS-1:0] obs_psel;
    logic [DW-1:0] obs_rdata, obs_pwdata;
    logic          obs_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("m_psel",    64'(dn.psel),     64'(exp_psel));
            chk("m_penable", 64'(dn.penable),  64'(exp_pen));
            chk("s_pready",  64'(up.pready),   64'(exp_rdy));
            chk("s_pslverr", 64'(up.pslverr),  64'(exp_err));
            chk("s_prdata",  64'(up.prdata),   64'(exp_rdata));
            chk("m_paddr",   64'(dn.paddr),    64'(up.paddr));
            chk("m_pwdata",  64'(dn.pwdata),   64'(up.pwdata));
            chk("m_pctl",    64'({dn.pwrite, dn.pstrb, dn.pprot}),
                             64'({up.pwrite, up.pstrb, up.pprot}));
            chk("err_irq",   64'(err_irq),     64'(m_irq));
            chk("err_type",  64'(err_type),    64'(m_type));
            chk("err_addr",  64'(err_addr),    64'(m_addr));
        end
    end

    function automatic logic pick_clr();
        return clr_force | (clr_rand && $urandom_range(0, 7) == 0);
    endfunction

    task automatic set_exp(input logic [NS-1:0] ps, input logic [NS-1:0] pe, input logic rdy,
                           input logic er, input logic [DW-1:0] rd);
        exp_psel = ps; exp_pen = pe; exp_rdy = rdy; exp_err = er; exp_rdata = rd;
    endtask

    // Closes the current cycle; applies the sticky-error rule at the clock edge.
    task automatic cyc_end(input bit cap, input logic [1:0] typ);
        @(negedge clk);
        obs_psel = dn.psel; obs_rdata = up.prdata; obs_err = up.pslverr; obs_pwdata = dn.pwdata;
        @(posedge clk);
        if (cap && (!m_irq || err_clr)) begin
            m_irq = 1'b1; m_type = typ; m_addr = up.paddr;
        end else if (err_clr) begin
            m_irq = 1'b0; m_type = 2'b00; m_addr = '0;
        end
        #1;
    endtask

    task automatic drive_slaves(input int tgt, input bit rdy, input bit serr,
                                input logic [DW-1:0] rd, output logic [DW-1:0] tgt_rd);
        logic [DW-1:0] d;
        tgt_rd = '0;
        for (int i = 0; i < int'(NS); i++) begin
            d = $urandom;
            if (i == tgt) begin
                if (rdy) d = rd;
                dn.pready[i]  = rdy;
                dn.pslverr[i] = serr;
                tgt_rd = d;
            end else begin
                dn.pready[i]  = 1'($urandom_range(0, 1));
                dn.pslverr[i] = 1'($urandom_range(0, 1));
            end
            dn.prdata[i*DW +: DW] = d;
        end
    endtask

    task automatic idle(input int n);
        logic [DW-1:0] trd;
        for (int c = 0; c < n; c++) begin
            up.psel = 1'b0; up.penable = 1'b0; up.paddr = $urandom;
            drive_slaves(-1, 1'b0, 1'b0, '0, trd);
            err_clr = pick_clr();
            set_exp('0, '0, 1'b0, 1'b0, '0);
            cyc_end(1'b0, 2'b00);
        end
    endtask

    task automatic xfer(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                        input int waits, input bit serr, input logic [DW-1:0] rdata,
                        input int drop_at, input bit clr_at_done,
                        output int ncyc, output logic [DW-1:0] got_rdata, output logic got_err,
                        output logic [NS-1:0] got_psel, output logic [DW-1:0] got_wdata);
        int            idx;
        bit            mapped, rdy, fin;
        logic [NS-1:0] oh;
        logic [DW-1:0] trd;
        logic [1:0]    typ;
        idx    = int'(addr[13:12]);
        mapped = (idx < int'(NS));
        oh     = mapped ? NS'(1 << idx) : '0;
        ncyc = 0; got_rdata = '0; got_err = 1'b0;
        up.psel = 1'b1; up.penable = 1'b0; up.paddr = addr; up.pwrite = wr; up.pwdata = wdata;
        up.pstrb = 4'($urandom); up.pprot = 3'($urandom);
        drive_slaves(idx, 1'b0, 1'b0, '0, trd);
        err_clr = pick_clr();
        set_exp(oh, '0, 1'b0, 1'b0, '0);
        cyc_end(1'b0, 2'b00);
        got_psel = obs_psel; got_wdata = obs_pwdata;
        for (int k = 1; k <= 64; k++) begin
            if (drop_at != 0 && k == drop_at + 1) begin
                up.psel = 1'b0; up.penable = 1'b0;
                drive_slaves(idx, 1'b0, 1'b0, '0, trd);
                err_clr = pick_clr();
                set_exp('0, '0, 1'b0, 1'b0, trd);
                cyc_end(1'b0, 2'b00);
                ncyc = k + 1;
                break;
            end
            up.penable = 1'b1;
            rdy = mapped && (k > waits);
            drive_slaves(idx, rdy, serr & rdy, rdata, trd);
            if (!mapped) begin
                set_exp('0, '0, 1'b1, 1'b1, '0); typ = 2'b01;
            end else if (rdy) begin
                set_exp(oh, oh, 1'b1, serr, rdata); typ = 2'b11;
            end else if (k == TO) begin
                set_exp(oh, oh, 1'b1, 1'b1, '0); typ = 2'b10;
            end else begin
                set_exp(oh, oh, 1'b0, 1'b0, trd); typ = 2'b00;
            end
            fin = exp_rdy;
            err_clr = (clr_at_done && fin) | pick_clr();
            cyc_end(fin && exp_err, typ);
            if (fin) begin
                ncyc = k + 1; got_rdata = obs_rdata; got_err = obs_err;
                break;
            end
        end
    endtask

    initial begin
        int            nc;
        logic [DW-1:0] rd, wd, trd;
        logic          er;
        logic [NS-1:0] ps;
        int            idx, waits, drop;
        logic [AW-1:0] addr;

        m_irq = 1'b0; m_type = '0; m_addr = '0; clr_force = 1'b0; clr_rand = 1'b0;
        up.psel = 1'b1; up.penable = 1'b0; up.paddr = 32'h0000_1000; up.pwrite = 1'b0;
        up.pstrb = '0; up.pprot = '0; up.pwdata = '0;
        dn.pready = '1; dn.pslverr = '1; dn.prdata = '1;
        #3;
        chk("rst_m_psel",   64'(dn.psel),    64'h0);
        chk("rst_m_pen",    64'(dn.penable), 64'h0);
        chk("rst_pready",   64'(up.pready),  64'h0);
        chk("rst_pslverr",  64'(up.pslverr), 64'h0);
        chk("rst_prdata",   64'(up.prdata),  64'h0);
        chk("rst_err",      64'({err_irq, err_type, err_addr}), 64'h0);
        @(negedge clk);
        rstn = 1'b1; up.psel = 1'b0;
        @(posedge clk); #1;
        exp_on = 1'b1;
        idle(2);

        xfer(32'h0000_1004, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, '0, 0, 1'b0, nc, rd, er, ps, wd);
        chk("wr_psel", 64'(ps), 64'h2);
        chk("wr_pwdata", 64'(wd), 64'hA5A5_A5A5);
        xfer(32'h0000_0008, 1'b0, '0, 0, 1'b0, 32'h1234_5678, 0, 1'b0, nc, rd, er, ps, wd);
        chk("rd_data", 64'(rd), 64'h1234_5678);
        chk("rd_cycles", 64'(nc), 64'd2);
        xfer(32'h0000_3000, 1'b0, '0, 0, 1'b0, '0, 0, 1'b0, nc, rd, er, ps, wd);
        chk("unmap_psel", 64'(ps), 64'h0);
        chk("unmap_resp", 64'({er, rd}), 64'h1_0000_0000);
        chk("unmap_cycles", 64'(nc), 64'd2);
        chk("unmap_err", 64'({err_irq, err_type, err_addr}), {31'h0, 1'b1, 2'b01, 32'h3000});
        clr_force = 1'b1; idle(1); clr_force = 1'b0;
        chk("clr_irq", 64'(err_irq), 64'h0);

        xfer(32'h0000_0010, 1'b0, '0, 100, 1'b0, '0, 0, 1'b0, nc, rd, er, ps, wd);
        chk("to_cycles", 64'(nc), 64'd5);
        chk("to_resp", 64'({er, rd}), 64'h1_0000_0000);
        chk("to_type", 64'({err_irq, err_type}), 64'b110);
        clr_force = 1'b1; idle(1); clr_force = 1'b0;
        xfer(32'h0000_0010, 1'b0, '0, 3, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, nc, rd, er, ps, wd);
        chk("late_rdy_cycles", 64'(nc), 64'd5);
        chk("late_rdy_resp", 64'({er, rd}), 64'h0_0BAD_CAFE);
        chk("late_rdy_irq", 64'(err_irq), 64'h0);

        xfer(32'h0000_3004, 1'b1, 32'h1, 0, 1'b0, '0, 0, 1'b0, nc, rd, er, ps, wd);
        xfer(32'h0000_1008, 1'b0, '0, 1, 1'b1, '0, 0, 1'b0, nc, rd, er, ps, wd);
        chk("sticky_keep", 64'({err_type, err_addr}), {30'h0, 2'b01, 32'h3004});
        xfer(32'h0000_1010, 1'b0, '0, 0, 1'b1, '0, 0, 1'b1, nc, rd, er, ps, wd);
        chk("clr_and_cap", 64'({err_irq, err_type, err_addr}), {31'h0, 1'b1, 2'b11, 32'h1010});

        // Reset in the second wait-stated ACCESS cycle of a transfer to slave 1.
        up.psel = 1'b1; up.penable = 1'b0; up.paddr = 32'h0000_1000; err_clr = 1'b0;
        drive_slaves(1, 1'b0, 1'b0, '0, trd);
        set_exp(3'b010, '0, 1'b0, 1'b0, '0);
        cyc_end(1'b0, 2'b00);
        up.penable = 1'b1;
        drive_slaves(1, 1'b0, 1'b0, '0, trd);
        set_exp(3'b010, 3'b010, 1'b0, 1'b0, trd);
        cyc_end(1'b0, 2'b00);
        drive_slaves(1, 1'b0, 1'b0, '0, trd);
        exp_on = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_sel", 64'({dn.psel, dn.penable}), 64'h0);
        chk("mid_rst_resp", 64'({up.pready, up.pslverr, up.prdata}), 64'h0);
        chk("mid_rst_err", 64'({err_irq, err_type, err_addr}), 64'h0);
        m_irq = 1'b0; m_type = '0; m_addr = '0;
        up.psel = 1'b0; up.penable = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        exp_on = 1'b1;
        xfer(32'h0000_2000, 1'b0, '0, 2, 1'b0, 32'hCAFE_F00D, 0, 1'b0, nc, rd, er, ps, wd);
        chk("post_rst_psel", 64'(ps), 64'h4);
        chk("post_rst_data", 64'(rd), 64'hCAFE_F00D);
        chk("post_rst_cycles", 64'(nc), 64'd4);

        clr_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            idx   = int'($urandom_range(0, 3));
            addr  = ($urandom & 32'hFFFF_CFFF) | (32'(idx) << 12);
            waits = int'($urandom_range(0, 5));
            drop  = (idx < int'(NS) && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (drop > waits) waits = drop;
            xfer(addr, 1'($urandom_range(0, 1)), $urandom, waits, ($urandom_range(0, 3) == 0),
                 $urandom, drop, 1'b0, nc, rd, er, ps, wd);
            idle(int'($urandom_range(0, 2)));
        end
        exp_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
